// File: rtl/uart_port_pkg.sv
// Shared definitions for the thinpad board UART port: address map,
// bus/TX state encodings and status register bit positions.
package thinpad_uart_pkg;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

    localparam int unsigned STAT_TX_READY_BIT = 0;
    localparam int unsigned STAT_RX_READY_BIT = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_RECOVER,
        WR_SETUP,
        WR_STROBE
    } bus_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_TBRE,
        TX_WAIT_TSRE
    } tx_state_t;

endpackage

// File: rtl/uart_port_rx_fifo.sv
// Receive prefetch buffer: power-of-two circular FIFO, pointers wrap naturally.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [15:0]              din,
    output logic [15:0]              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];
    assign w_do_pop  = pop && !empty;
    // a pop frees a slot in the same edge, so a full FIFO may still accept
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/uart_port.sv
// Board UART port: bus FSM driving rdn/wrn strobes, RX prefetch FIFO and
// TX completion tracker; loads are answered in the same cycle.
module uart_port
    import thinpad_uart_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int RD_LOW   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic        sel_status,
    input  logic [7:0]  wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn,
    input  logic [7:0]  bus_i,
    output logic [7:0]  bus_o,
    output logic        bus_oe
);
    localparam int CNT_W = (RD_LOW > 1) ? $clog2(RD_LOW) : 1;
    localparam int AW    = $clog2(RX_DEPTH);

    bus_state_t       r_state, w_state_nx;
    tx_state_t        r_tx, w_tx_nx;
    logic [CNT_W-1:0] r_rd_cnt, w_rd_cnt_nx;
    logic [7:0]       r_wbyte, w_wbyte_nx;

    logic        w_push, w_pop, w_full, w_empty;
    logic [15:0] w_dout;
    logic [AW:0] w_count;
    logic        w_in_wr, w_rd_last, w_store, w_load;

    assign w_in_wr   = (r_state == WR_SETUP) || (r_state == WR_STROBE);
    assign w_rd_last = (r_state == RD_STROBE) && (r_rd_cnt == CNT_W'(RD_LOW - 1));
    assign w_store   = req_wr && !sel_status;
    assign w_load    = req_rd && !req_wr && !sel_status;
    assign w_push    = w_rd_last && !rst;
    assign w_pop     = w_load && !w_empty && !w_in_wr && !rst;

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({8'h00, bus_i}),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tx     <= TX_IDLE;
            r_rd_cnt <= '0;
            r_wbyte  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_tx     <= w_tx_nx;
            r_rd_cnt <= w_rd_cnt_nx;
            r_wbyte  <= w_wbyte_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_tx_nx     = r_tx;
        w_rd_cnt_nx = r_rd_cnt;
        w_wbyte_nx  = r_wbyte;
        case (r_state)
            IDLE: begin
                if (w_store && (r_tx == TX_IDLE)) begin
                    w_state_nx = WR_SETUP;
                    w_wbyte_nx = wdata;
                end else if (data_ready && !w_full) begin
                    w_state_nx  = RD_STROBE;
                    w_rd_cnt_nx = '0;
                end
            end
            RD_STROBE: begin
                if (w_rd_last) begin
                    w_state_nx  = RD_RECOVER;
                    w_rd_cnt_nx = '0;
                end else begin
                    w_rd_cnt_nx = r_rd_cnt + CNT_W'(1);
                end
            end
            RD_RECOVER: w_state_nx = IDLE;
            WR_SETUP:   w_state_nx = WR_STROBE;
            WR_STROBE:  w_state_nx = IDLE;
            default:    w_state_nx = IDLE;
        endcase

        case (r_tx)
            TX_WAIT_TBRE: if (tbre) w_tx_nx = TX_WAIT_TSRE;
            TX_WAIT_TSRE: if (tsre) w_tx_nx = TX_IDLE;
            default:      w_tx_nx = TX_IDLE;
        endcase
        if (r_state == WR_STROBE) begin
            w_tx_nx = TX_WAIT_TBRE;
        end
    end

    always_comb begin
        rdn    = (r_state != RD_STROBE);
        wrn    = (r_state != WR_STROBE);
        bus_oe = w_in_wr;
        bus_o  = w_in_wr ? r_wbyte : '0;
        busy   = 1'b0;
        done   = 1'b0;
        rdata  = '0;
        if (w_in_wr) begin
            busy = 1'b1;
            done = (r_state == WR_STROBE);
        end else if (req_wr) begin
            // status-address stores are dropped; data stores stall until taken
            if (sel_status) begin
                done = 1'b1;
            end else begin
                busy = 1'b1;
            end
        end else if (req_rd) begin
            done = 1'b1;
            if (sel_status) begin
                rdata[STAT_RX_READY_BIT] = (w_count != '0);
                rdata[STAT_TX_READY_BIT] = (r_tx == TX_IDLE) && !w_in_wr;
            end else if (!w_empty) begin
                rdata = w_dout;
            end
        end
    end

endmodule

// File: tb/tb_uart_port.sv
// Directed self-checking bench for uart_port: prefetch, FIFO ordering,
// push/pop overlap, TX tracker stalls, status accesses and reset abort.
module tb_uart_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic        sel_status = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        data_ready = 1'b0;
    logic        tbre = 1'b1;
    logic        tsre = 1'b1;
    logic        rdn;
    logic        wrn;
    logic [7:0]  bus_i = 8'h00;
    logic [7:0]  bus_o;
    logic        bus_oe;

    int n_chk  = 0;
    int n_pass = 0;

    uart_port #(.RX_DEPTH(4), .RD_LOW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .sel_status (sel_status),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .rdn        (rdn),
        .wrn        (wrn),
        .bus_i      (bus_i),
        .bus_o      (bus_o),
        .bus_oe     (bus_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_chk++; if ({rdn, wrn, bus_oe} !== 3'b110) $display("FAIL rst_strobes: got %b want 110", {rdn, wrn, bus_oe}); else n_pass++;
        n_chk++; if (bus_o !== 8'h00) $display("FAIL rst_bus_o: got %h want 00", bus_o); else n_pass++;
        n_chk++; if ({busy, done} !== 2'b00) $display("FAIL rst_busy_done: got %b want 00", {busy, done}); else n_pass++;
        n_chk++; if (rdata !== 16'h0000) $display("FAIL rst_rdata: got %h want 0000", rdata); else n_pass++;
        rst = 1'b0;
        tick();
        req_rd = 1'b1; sel_status = 1'b1;
        #1;
        n_chk++; if (rdata !== 16'h0001) $display("FAIL rst_status: got %h want 0001", rdata); else n_pass++;
        n_chk++; if ({busy, done} !== 2'b01) $display("FAIL rst_status_hs: got %b want 01", {busy, done}); else n_pass++;
        req_rd = 1'b0; sel_status = 1'b0;
    endtask

    task automatic test_prefetch();
        tick();
        data_ready = 1'b1; bus_i = 8'h41;
        #1;
        n_chk++; if (rdn !== 1'b1) $display("FAIL pf_rdn_c0: got %b want 1", rdn); else n_pass++;
        tick();
        data_ready = 1'b0;
        #1;
        n_chk++; if ({rdn, wrn} !== 2'b01) $display("FAIL pf_rdn_c1: got %b want 01", {rdn, wrn}); else n_pass++;
        tick();
        n_chk++; if ({rdn, wrn, bus_oe} !== 3'b010) $display("FAIL pf_rdn_c2: got %b want 010", {rdn, wrn, bus_oe}); else n_pass++;
        tick();
        n_chk++; if (rdn !== 1'b1) $display("FAIL pf_rdn_c3: got %b want 1", rdn); else n_pass++;
        tick();
        req_rd = 1'b1; sel_status = 1'b1;
        #1;
        n_chk++; if (rdata !== 16'h0003) $display("FAIL pf_status: got %h want 0003", rdata); else n_pass++;
        sel_status = 1'b0;
        #1;
        n_chk++; if (rdata !== 16'h0041) $display("FAIL pf_data: got %h want 0041", rdata); else n_pass++;
        n_chk++; if ({busy, done} !== 2'b01) $display("FAIL pf_data_hs: got %b want 01", {busy, done}); else n_pass++;
        tick();
        req_rd = 1'b0;
    endtask

    task automatic test_fill_order();
        int low_cycles = 0;
        int both_low = 0;
        data_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (!rdn && !wrn) both_low++;
            if (!rdn) begin
                low_cycles++;
                bus_i = 8'h10 + 8'((low_cycles - 1) / 2);
            end
            tick();
        end
        data_ready = 1'b0;
        n_chk++; if (low_cycles !== 8) $display("FAIL fill_rdn_low: got %0d want 8", low_cycles); else n_pass++;
        n_chk++; if (both_low !== 0) $display("FAIL fill_strobe_overlap: got %0d want 0", both_low); else n_pass++;
        req_rd = 1'b1; sel_status = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [15:0] exp;
            exp = (k < 4) ? (16'h0010 + 16'(k)) : 16'h0000;
            #1;
            n_chk++; if (rdata !== exp) $display("FAIL fill_load%0d: got %h want %h", k, rdata, exp); else n_pass++;
            n_chk++; if (done !== 1'b1) $display("FAIL fill_done%0d: got %b want 1", k, done); else n_pass++;
            tick();
        end
        req_rd = 1'b0;
    endtask

    task automatic test_push_pop();
        data_ready = 1'b1; bus_i = 8'h33;
        tick();
        data_ready = 1'b0;
        tick();
        tick();
        tick();
        data_ready = 1'b1; bus_i = 8'h42;
        tick();
        data_ready = 1'b0;
        tick();
        req_rd = 1'b1; sel_status = 1'b0;
        #1;
        n_chk++; if (rdn !== 1'b0) $display("FAIL pp_last_strobe: got %b want 0", rdn); else n_pass++;
        n_chk++; if (rdata !== 16'h0033) $display("FAIL pp_first: got %h want 0033", rdata); else n_pass++;
        tick();
        sel_status = 1'b1;
        #1;
        n_chk++; if (rdata !== 16'h0003) $display("FAIL pp_status: got %h want 0003", rdata); else n_pass++;
        sel_status = 1'b0;
        #1;
        n_chk++; if (rdata !== 16'h0042) $display("FAIL pp_second: got %h want 0042", rdata); else n_pass++;
        tick();
        #1;
        n_chk++; if (rdata !== 16'h0000) $display("FAIL pp_empty: got %h want 0000", rdata); else n_pass++;
        req_rd = 1'b0;
        tick();
    endtask

    task automatic test_write_stall();
        int stall_bad = 0;
        tbre = 1'b0; tsre = 1'b0;
        req_wr = 1'b1; sel_status = 1'b0; wdata = 8'h5A;
        #1;
        n_chk++; if ({busy, done} !== 2'b10) $display("FAIL wr_take: got %b want 10", {busy, done}); else n_pass++;
        tick();
        n_chk++; if ({bus_oe, wrn, busy} !== 3'b111) $display("FAIL wr_setup: got %b want 111", {bus_oe, wrn, busy}); else n_pass++;
        n_chk++; if (bus_o !== 8'h5A) $display("FAIL wr_setup_data: got %h want 5a", bus_o); else n_pass++;
        tick();
        n_chk++; if ({bus_oe, wrn, rdn, done} !== 4'b1011) $display("FAIL wr_strobe: got %b want 1011", {bus_oe, wrn, rdn, done}); else n_pass++;
        n_chk++; if (bus_o !== 8'h5A) $display("FAIL wr_strobe_data: got %h want 5a", bus_o); else n_pass++;
        req_wr = 1'b0;
        tick();
        n_chk++; if ({bus_oe, wrn} !== 2'b01) $display("FAIL wr_after: got %b want 01", {bus_oe, wrn}); else n_pass++;
        req_rd = 1'b1; sel_status = 1'b1;
        #1;
        n_chk++; if (rdata !== 16'h0000) $display("FAIL wr_status_busy: got %h want 0000", rdata); else n_pass++;
        req_rd = 1'b0; sel_status = 1'b0;
        req_wr = 1'b1; wdata = 8'hA5;
        for (int c = 0; c < 9; c++) begin
            if (c == 4) tbre = 1'b1;
            if (c == 8) tsre = 1'b1;
            #1;
            if (!busy || !wrn || bus_oe || done) stall_bad++;
            tick();
        end
        n_chk++; if (stall_bad !== 0) $display("FAIL wr_stall: got %0d bad cycles want 0", stall_bad); else n_pass++;
        n_chk++; if ({busy, bus_oe} !== 2'b10) $display("FAIL wr2_take: got %b want 10", {busy, bus_oe}); else n_pass++;
        tick();
        n_chk++; if (bus_o !== 8'hA5) $display("FAIL wr2_setup: got %h want a5", bus_o); else n_pass++;
        tick();
        n_chk++; if ({wrn, done} !== 2'b01) $display("FAIL wr2_strobe: got %b want 01", {wrn, done}); else n_pass++;
        req_wr = 1'b0;
        tick();
        tick();
        tick();
        req_rd = 1'b1; sel_status = 1'b1;
        #1;
        n_chk++; if (rdata !== 16'h0001) $display("FAIL wr_status_idle: got %h want 0001", rdata); else n_pass++;
        req_rd = 1'b0; sel_status = 1'b0;
    endtask

    task automatic test_status_store();
        req_wr = 1'b1; sel_status = 1'b1; wdata = 8'hFF;
        #1;
        n_chk++; if ({busy, done, bus_oe} !== 3'b010) $display("FAIL st_store: got %b want 010", {busy, done, bus_oe}); else n_pass++;
        tick();
        n_chk++; if ({wrn, bus_oe} !== 2'b10) $display("FAIL st_store_next: got %b want 10", {wrn, bus_oe}); else n_pass++;
        req_rd = 1'b1;
        #1;
        n_chk++; if ({rdata, done, busy} !== {16'h0000, 2'b10}) $display("FAIL rd_wr_both: got %h/%b want 0000/10", rdata, {done, busy}); else n_pass++;
        req_rd = 1'b0; req_wr = 1'b0; sel_status = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        data_ready = 1'b1; bus_i = 8'h77;
        tick();
        data_ready = 1'b0;
        tick();
        #1;
        n_chk++; if (rdn !== 1'b0) $display("FAIL rm_strobe: got %b want 0", rdn); else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++; if (rdn !== 1'b1) $display("FAIL rm_rdn: got %b want 1", rdn); else n_pass++;
        rst = 1'b0;
        req_rd = 1'b1; sel_status = 1'b1;
        #1;
        n_chk++; if (rdata !== 16'h0001) $display("FAIL rm_status: got %h want 0001", rdata); else n_pass++;
        sel_status = 1'b0;
        #1;
        n_chk++; if (rdata !== 16'h0000) $display("FAIL rm_data: got %h want 0000", rdata); else n_pass++;
        req_rd = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_prefetch();
        test_fill_order();
        test_push_pop();
        test_write_stall();
        test_status_store();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
